// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch issue stage and its consumers.
// Holds the datapath widths, the operand packet layout and the immediate extender.
package operand_fetch_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREG   = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned IMM_W  = 8;

    // Operand packet handed to the ALU stage; b occupies the low bits.
    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [ADDR_W-1:0] rdest;
        logic              wr;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } opnd_pkt_t;

    localparam int unsigned PKT_B_LSB     = 0;
    localparam int unsigned PKT_A_LSB     = PKT_B_LSB + DATA_W;
    localparam int unsigned PKT_WR_LSB    = PKT_A_LSB + DATA_W;
    localparam int unsigned PKT_RDEST_LSB = PKT_WR_LSB + 1;
    localparam int unsigned PKT_OP_LSB    = PKT_RDEST_LSB + ADDR_W;
    localparam int unsigned PKT_W         = PKT_OP_LSB + OP_W;

    function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                  input logic             zx);
        if (zx)
            return {{(DATA_W-IMM_W){1'b0}}, imm};
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Issue-stage bundle: regfile/writeback view, decoded instruction in, operand packet out.
// slave = the operand_fetch stage, master = the surrounding pipeline.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic [NREG*DATA_W-1:0] regs_flat;
    logic [DATA_W-1:0]      ALUBus;
    logic [NREG-1:0]        regEnable;

    logic                   in_valid;
    logic                   in_ready;
    logic [OP_W-1:0]        in_opcode;
    logic [ADDR_W-1:0]      in_rdest;
    logic [ADDR_W-1:0]      in_rsrc;
    logic [IMM_W-1:0]       in_imm;
    logic                   in_imm_sel;
    logic                   in_imm_zx;
    logic                   in_wr;
    logic                   flush;

    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_a;
    logic [DATA_W-1:0]      out_b;
    logic [OP_W-1:0]        out_opcode;
    logic [ADDR_W-1:0]      out_rdest;
    logic                   out_wr;

    modport slave (
        input  regs_flat, ALUBus, regEnable,
        input  in_valid, in_opcode, in_rdest, in_rsrc, in_imm, in_imm_sel, in_imm_zx, in_wr,
        input  flush, out_ready,
        output in_ready, out_valid, out_a, out_b, out_opcode, out_rdest, out_wr
    );

    modport master (
        output regs_flat, ALUBus, regEnable,
        output in_valid, in_opcode, in_rdest, in_rsrc, in_imm, in_imm_sel, in_imm_zx, in_wr,
        output flush, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_opcode, out_rdest, out_wr
    );

endinterface

// File: rtl/operand_fetch_reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A bit being written back this cycle is already reported as not busy.
module reg_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_idx_i,
    input  logic [NREG-1:0]   clr_vec_i,
    input  logic              flush_en_i,
    input  logic [ADDR_W-1:0] flush_idx_i,
    output logic [NREG-1:0]   busy_c_o
);

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;

    // A new issue claiming the register beats any clear in the same cycle.
    always_comb begin
        sb_d = sb_q;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (set_en_i && (set_idx_i == ADDR_W'(i)))
                sb_d[i] = 1'b1;
            else if (clr_vec_i[i] || (flush_en_i && (flush_idx_i == ADDR_W'(i))))
                sb_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sb_q <= '0;
        else
            sb_q <= sb_d;
    end

    assign busy_c_o = sb_q & ~clr_vec_i;

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: picks operands from the register file with same-cycle writeback bypass,
// stalls on scoreboard hazards and holds one registered operand packet for the ALU.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    operand_fetch_if.slave bus
);

    logic [DATA_W-1:0] regs_arr [NREG];
    logic [NREG-1:0]   busy_c;
    logic              hazard_c;
    logic              in_ready_c;
    logic              accept_c;
    logic              flush_sb_c;
    logic [DATA_W-1:0] opa_c;
    logic [DATA_W-1:0] opb_c;

    opnd_pkt_t pkt_q, pkt_d;
    logic      valid_q, valid_d;

    always_comb begin
        for (int unsigned i = 0; i < NREG; i++)
            regs_arr[i] = bus.regs_flat[i*DATA_W +: DATA_W];
    end

    // Operand selection; a register being written this cycle reads the writeback bus.
    always_comb begin
        opa_c = bus.regEnable[bus.in_rdest] ? bus.ALUBus : regs_arr[bus.in_rdest];
        if (bus.in_imm_sel)
            opb_c = ext_imm(bus.in_imm, bus.in_imm_zx);
        else
            opb_c = bus.regEnable[bus.in_rsrc] ? bus.ALUBus : regs_arr[bus.in_rsrc];
    end

    assign hazard_c   = busy_c[bus.in_rdest] | (~bus.in_imm_sel & busy_c[bus.in_rsrc]);
    assign in_ready_c = ~bus.flush & ~hazard_c & (~valid_q | bus.out_ready);
    assign accept_c   = bus.in_valid & in_ready_c;
    assign flush_sb_c = bus.flush & valid_q & pkt_q.wr;

    reg_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (reset),
        .set_en_i    (accept_c & bus.in_wr),
        .set_idx_i   (bus.in_rdest),
        .clr_vec_i   (bus.regEnable),
        .flush_en_i  (flush_sb_c),
        .flush_idx_i (pkt_q.rdest),
        .busy_c_o    (busy_c)
    );

    // Pipeline register: load on accept, drop valid on consume or flush, data holds.
    always_comb begin
        pkt_d   = pkt_q;
        valid_d = valid_q;
        if (accept_c) begin
            pkt_d.opcode = bus.in_opcode;
            pkt_d.rdest  = bus.in_rdest;
            pkt_d.wr     = bus.in_wr;
            pkt_d.a      = opa_c;
            pkt_d.b      = opb_c;
            valid_d      = 1'b1;
        end else if (bus.flush || (valid_q && bus.out_ready)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pkt_q   <= pkt_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = valid_q;
    assign bus.out_a      = pkt_q.a;
    assign bus.out_b      = pkt_q.b;
    assign bus.out_opcode = pkt_q.opcode;
    assign bus.out_rdest  = pkt_q.rdest;
    assign bus.out_wr     = pkt_q.wr;

endmodule
